// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache.
// Geometry: 8 lines x 4 words x 32 bits. Word address layout is
// [1:0] word offset, [4:2] line index, [29:5] tag.
//
// Ports
//   clk, rst_n           clock, async active-low reset
//   proc_read/proc_write pipeline load/store request (write wins if both)
//   proc_addr[29:0]      word address
//   proc_wdata[31:0]     store data
//   proc_stall           request cannot complete this cycle
//   proc_rdata[31:0]     load data (valid on read hit in IDLE)
//   mem_read/mem_write   line fetch / write-back request (never both)
//   mem_addr[27:0]       line address {tag,index}
//   mem_wdata[127:0]     victim line, word 0 in [31:0]
//   mem_rdata[127:0]     fetched line, word 0 in [31:0]
//   mem_ready            one-cycle completion pulse for the memory request
//
// state     | meaning
// IDLE      | serve hits; on a miss pick WRITEBACK (dirty victim) or ALLOCATE
// WRITEBACK | mem_write asserted with victim line until mem_ready
// ALLOCATE  | mem_read asserted for the requested line until mem_ready
module data_cache (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic         proc_stall,
    output logic [31:0]  proc_rdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t       state_q;
    logic [7:0]   valid_q;
    logic [7:0]   dirty_q;
    logic [24:0]  tag_q  [8];
    logic [127:0] data_q [8];
    logic         mem_read_q;
    logic         mem_write_q;

    logic [2:0]   idx;
    logic [1:0]   woff;
    logic [24:0]  req_tag;
    logic         hit;
    logic         req;

    assign idx     = proc_addr[4:2];
    assign woff    = proc_addr[1:0];
    assign req_tag = proc_addr[29:5];
    assign hit     = valid_q[idx] && (tag_q[idx] == req_tag);
    assign req     = proc_read || proc_write;

    assign proc_stall = (state_q != IDLE) || (req && !hit);
    assign proc_rdata = data_q[idx][{woff, 5'd0} +: 32];

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    // Outside WRITEBACK the only meaningful address is the refill target.
    assign mem_addr  = (state_q == WRITEBACK) ? {tag_q[idx], idx} : proc_addr[29:2];
    assign mem_wdata = data_q[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req && !hit) begin
                        if (valid_q[idx] && dirty_q[idx]) begin
                            state_q     <= WRITEBACK;
                            mem_write_q <= 1'b1;
                        end else begin
                            state_q    <= ALLOCATE;
                            mem_read_q <= 1'b1;
                        end
                    end else if (proc_write && hit) begin
                        dirty_q[idx] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) begin
                        state_q     <= ALLOCATE;
                        mem_write_q <= 1'b0;
                        mem_read_q  <= 1'b1;
                    end
                end
                ALLOCATE: begin
                    if (mem_ready) begin
                        state_q      <= IDLE;
                        mem_read_q   <= 1'b0;
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid_q guards their contents.
    // During reset state_q is IDLE and valid_q is clear, so nothing is written.
    always_ff @(posedge clk) begin
        if (state_q == ALLOCATE && mem_ready) begin
            data_q[idx] <= mem_rdata;
            tag_q[idx]  <= req_tag;
        end else if (state_q == IDLE && proc_write && hit) begin
            data_q[idx][{woff, 5'd0} +: 32] <= proc_wdata;
        end
    end

endmodule
